lfsr_run_ctrl: RTL and testbench

- Sequencing controller for the LFSR display datapath.
- Replaces the ad-hoc divider and edge logic in the board top.
- Generates single-cycle LFSR enable pulses in three modes: free-running at a selectable rate, paused, or single-step from a button.
- Also produces the seven-segment digit-select strobe and a pulse counter for LED/debug.

---
 rtl/lfsr_ctrl_pkg.sv | 14 +
 rtl/rise_detect.sv | 21 ++
 rtl/lfsr_run_ctrl.sv | 134 +++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and widths for the LFSR run/pause/step sequencing controller.
package lfsr_ctrl_pkg;

    localparam int unsigned SPEED_W = 2;
    localparam int unsigned STATE_W = 2;
    localparam int unsigned EN_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        PAUSED  = 2'b00,
        RUNNING = 2'b01,
        STEP    = 2'b10
    } state_e;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already synchronized, debounced level.
module rise_detect (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic rise_c
);

    logic r_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d_i;
        end
    end

    assign rise_c = d_i & ~r_q;

endmodule

// File: rtl/lfsr_run_ctrl.sv
// Sequencer for the LFSR display path: free-run / pause / single-step enables,
// digit-mux strobe and a pulse counter.
module lfsr_run_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned tick_width_p  = 22,
    parameter int unsigned digit_width_p = 14
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                run_i,
    input  logic                step_i,
    input  logic [SPEED_W-1:0]  speed_i,
    output logic                lfsr_en_o,
    output logic                digit_sel_o,
    output logic [STATE_W-1:0]  state_o,
    output logic [EN_CNT_W-1:0] en_count_o
);

    localparam int unsigned TW = tick_width_p;
    localparam int unsigned DW = digit_width_p;

    logic                w_run_edge;
    logic                w_step_edge;
    logic                w_tick;
    logic                w_presc_clr;
    logic                w_en_nxt;
    logic [TW-1:0]       w_mask;
    logic [DW-1:0]       w_digit_nxt;
    state_e              w_state_nxt;

    state_e              r_state;
    logic [TW-1:0]       r_presc;
    logic                r_en;
    logic [EN_CNT_W-1:0] r_cnt;
    logic [DW-1:0]       r_digit;
    logic                r_digit_sel;

    rise_detect u_run_rise (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (run_i),
        .rise_c    (w_run_edge)
    );

    rise_detect u_step_rise (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (step_i),
        .rise_c    (w_step_edge)
    );

    // Faster speeds compare fewer low prescaler bits.
    assign w_mask = {TW{1'b1}} >> speed_i;
    assign w_tick = (r_state == RUNNING) && ((r_presc & w_mask) == w_mask);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= RUNNING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A run edge always wins over a coincident tick or step edge.
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_presc_clr = 1'b0;
        case (r_state)
            RUNNING: begin
                if (w_run_edge) begin
                    w_state_nxt = PAUSED;
                end else if (w_tick) begin
                    w_en_nxt = 1'b1;
                end
            end
            PAUSED: begin
                if (w_run_edge) begin
                    w_state_nxt = RUNNING;
                    w_presc_clr = 1'b1;
                end else if (w_step_edge) begin
                    w_state_nxt = STEP;
                    w_en_nxt    = 1'b1;
                end
            end
            STEP: begin
                if (w_run_edge) begin
                    w_state_nxt = RUNNING;
                    w_presc_clr = 1'b1;
                end else begin
                    w_state_nxt = PAUSED;
                end
            end
            default: begin
                w_state_nxt = RUNNING;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_presc <= '0;
            r_en    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_presc_clr) begin
                r_presc <= '0;
            end else if (r_state == RUNNING) begin
                r_presc <= r_presc + TW'(1);
            end
            r_en  <= w_en_nxt;
            r_cnt <= r_cnt + EN_CNT_W'(w_en_nxt);
        end
    end

    assign w_digit_nxt = r_digit + DW'(1);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_digit     <= '0;
            r_digit_sel <= 1'b0;
        end else begin
            r_digit     <= w_digit_nxt;
            r_digit_sel <= w_digit_nxt[DW-1];
        end
    end

    assign lfsr_en_o   = r_en;
    assign digit_sel_o = r_digit_sel;
    assign state_o     = r_state;
    assign en_count_o  = r_cnt;

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Scoreboard bench for lfsr_run_ctrl: a cycle-level behavioural model queues
// expected outputs; a monitor compares them after every clock edge.
module tb_lfsr_run_ctrl;

    localparam int TW = 4;
    localparam int DW = 3;
    localparam int M_PAUSE = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       step;
    logic [1:0] speed;
    logic       lfsr_en;
    logic       digit_sel;
    logic [1:0] state;
    logic [7:0] en_count;

    typedef struct packed {
        logic       en;
        logic       dsel;
        logic [1:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   rel_pending = 1'b0;
    bit   prev_en = 1'b0;

    int   m_mode, m_presc, m_cnt, m_cyc;
    bit   m_rq, m_sq, m_en;

    lfsr_run_ctrl #(
        .tick_width_p  (TW),
        .digit_width_p (DW)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .run_i       (run),
        .step_i      (step),
        .speed_i     (speed),
        .lfsr_en_o   (lfsr_en),
        .digit_sel_o (digit_sel),
        .state_o     (state),
        .en_count_o  (en_count)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_mode = M_RUN; m_presc = 0; m_cnt = 0; m_cyc = 0;
        m_rq = 1'b0; m_sq = 1'b0; m_en = 1'b0;
    endtask

    // One clock of the behavioural model, given the levels seen before the edge.
    task automatic m_step(input bit r, input bit s, input int spd);
        bit re, se, tick;
        int period;
        re     = r && !m_rq;
        se     = s && !m_sq;
        period = 1 << (TW - spd);
        tick   = (m_mode == M_RUN) && ((m_presc % period) == period - 1);
        m_en   = 1'b0;
        if (m_mode == M_RUN) begin
            m_presc = (m_presc + 1) % (1 << TW);
            if (re) m_mode = M_PAUSE;
            else if (tick) m_en = 1'b1;
        end else if (m_mode == M_PAUSE) begin
            if (re) begin m_mode = M_RUN; m_presc = 0; end
            else if (se) begin m_mode = M_STEP; m_en = 1'b1; end
        end else begin
            if (re) begin m_mode = M_RUN; m_presc = 0; end
            else m_mode = M_PAUSE;
        end
        m_cnt = (m_cnt + (m_en ? 1 : 0)) % 256;
        m_rq  = r;
        m_sq  = s;
        m_cyc = m_cyc + 1;
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.en   = m_en;
        e.dsel = ((m_cyc / (1 << (DW - 1))) % 2) == 1;
        e.st   = (m_mode == M_PAUSE) ? 2'b00 : (m_mode == M_RUN) ? 2'b01 : 2'b10;
        e.cnt  = 8'(m_cnt);
        return e;
    endfunction

    task automatic cycle(input bit r, input bit s, input logic [1:0] spd);
        @(negedge clk);
        if (rel_pending) begin
            reset_n     = 1'b1;
            rel_pending = 1'b0;
        end
        run   = r;
        step  = s;
        speed = spd;
        if (reset_n) m_step(r, s, int'(spd));
        sb_q.push_back(m_expect());
        mon_en = 1'b1;
    endtask

    // Asynchronous reset mid-cycle, checked before any further clock edge.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        #1;
        checks++;
        if ({lfsr_en, digit_sel, state, en_count} !== {1'b0, 1'b0, 2'b01, 8'd0}) begin
            failures++;
            $display("FAIL async_reset got en=%0b sel=%0b st=%0b cnt=%0d required en=0 sel=0 st=01 cnt=0",
                     lfsr_en, digit_sel, state, en_count);
        end
        m_reset();
        repeat (hold) cycle(1'b0, 1'b0, speed);
        rel_pending = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                got = {lfsr_en, digit_sel, state, en_count};
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_underflow at %0t got en=%0b st=%0b cnt=%0d required a queued expectation",
                             $time, lfsr_en, state, en_count);
                end else begin
                    e = sb_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL outputs at %0t got en=%0b sel=%0b st=%b cnt=%0d required en=%0b sel=%0b st=%b cnt=%0d",
                                 $time, got.en, got.dsel, got.st, got.cnt, e.en, e.dsel, e.st, e.cnt);
                    end
                end
                if (lfsr_en) begin
                    checks++;
                    if (prev_en) begin
                        failures++;
                        $display("FAIL double_pulse at %0t got en high twice required single-cycle", $time);
                    end
                end
                prev_en = lfsr_en;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got no finish required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit         r;
        bit         s;
        bit         seen255;
        int         budget;
        logic [1:0] sp;

        reset_n = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        speed   = 2'd0;
        m_reset();
        repeat (2) cycle(1'b0, 1'b0, 2'd0);
        rel_pending = 1'b1;

        // Free-run at the slowest rate.
        repeat (40) cycle(1'b0, 1'b0, 2'd0);

        // Fresh reset, faster rate.
        do_reset(2);
        repeat (24) cycle(1'b0, 1'b0, 2'd2);

        // Pause with a held run button, then idle.
        repeat (10) cycle(1'b1, 1'b0, 2'd0);
        repeat (100) cycle(1'b0, 1'b0, 2'd0);

        // Three single steps.
        repeat (3) begin
            repeat (5) cycle(1'b0, 1'b1, 2'd0);
            repeat (5) cycle(1'b0, 1'b0, 2'd0);
        end

        // Run and step together: run wins, prescaler restarts.
        repeat (3) cycle(1'b1, 1'b1, 2'd0);
        repeat (20) cycle(1'b0, 1'b0, 2'd0);

        // Random button levels and speed changes.
        r  = 1'b0;
        s  = 1'b0;
        sp = 2'd1;
        repeat (300) begin
            if ($urandom_range(7) == 0) r = ~r;
            if ($urandom_range(5) == 0) s = ~s;
            if ($urandom_range(19) == 0) sp = 2'($urandom_range(3));
            cycle(r, s, sp);
        end
        repeat (2) cycle(1'b0, 1'b0, 2'd3);
        if (m_mode != M_RUN) begin
            cycle(1'b1, 1'b0, 2'd3);
            cycle(1'b0, 1'b0, 2'd3);
        end

        // Count through 255 and wrap to 0.
        seen255 = 1'b0;
        budget  = 0;
        while (!(seen255 && m_cnt == 0) && budget < 1500) begin
            cycle(1'b0, 1'b0, 2'd3);
            if (m_cnt == 255) seen255 = 1'b1;
            budget++;
        end

        // Reset between edges, then resume.
        do_reset(2);
        repeat (20) cycle(1'b0, 1'b0, 2'd2);

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d left required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
